// File: rtl/shift_sequencer_32bit.sv
// Multi-cycle 32-bit shift/rotate sequencer: one single-bit LSL/LSR/ASR/ROL step per clock,
// with a start/ready handshake and a one-cycle done pulse.
module shift_sequencer_32bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [4:0]  amt_i,
  input  logic [31:0] din_i,
  output logic        ready_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] dout_o,
  output logic        cout_o
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [1:0] OpLsl = 2'b00;
  localparam logic [1:0] OpLsr = 2'b01;
  localparam logic [1:0] OpAsr = 2'b10;
  localparam logic [1:0] OpRol = 2'b11;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [1:0]  op_q;
  logic [31:0] dout_q;
  logic        cout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 5'd0;
      op_q    <= OpLsl;
      dout_q  <= 32'd0;
      cout_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            dout_q  <= din_i;
            op_q    <= op_i;
            cnt_q   <= amt_i;
            cout_q  <= 1'b0;
            state_q <= (amt_i == 5'd0) ? StDone : StShift;
          end
        end
        StShift: begin
          unique case (op_q)
            OpLsl: begin
              dout_q <= {dout_q[30:0], 1'b0};
              cout_q <= dout_q[31];
            end
            OpLsr: begin
              dout_q <= {1'b0, dout_q[31:1]};
              cout_q <= dout_q[0];
            end
            OpAsr: begin
              dout_q <= {dout_q[31], dout_q[31:1]};
              cout_q <= dout_q[0];
            end
            OpRol: begin
              dout_q <= {dout_q[30:0], dout_q[31]};
              cout_q <= dout_q[31];
            end
            default: ;
          endcase
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Status flags decode straight from the state register; no input reaches an output.
  assign ready_o = (state_q == StIdle);
  assign busy_o  = (state_q == StShift);
  assign done_o  = (state_q == StDone);
  assign dout_o  = dout_q;
  assign cout_o  = cout_q;

endmodule

// File: tb/tb_shift_sequencer_32bit.sv
// Directed, table-driven bench for shift_sequencer_32bit with hand-written reset and
// start-during-operation sequences.
module tb_shift_sequencer_32bit;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [1:0]  op_i;
  logic [4:0]  amt_i;
  logic [31:0] din_i;
  logic        ready_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] dout_o;
  logic        cout_o;

  int checks = 0;
  int errors = 0;

  shift_sequencer_32bit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .op_i    (op_i),
    .amt_i   (amt_i),
    .din_i   (din_i),
    .ready_o (ready_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .dout_o  (dout_o),
    .cout_o  (cout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  amt;
    logic [31:0] din;
    logic [31:0] exp_dout;
    logic        exp_cout;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Accept one operation, track it to done, and check result, latency and handshake.
  // With noise set, start is pulsed with junk operands during SHIFT and DONE.
  task automatic run_op(input logic [1:0] op, input logic [4:0] amt, input logic [31:0] din,
                        input logic [31:0] exp_dout, input logic exp_cout, input bit noise);
    int cycles;
    int busy_cnt;
    bit seen;
    logic [31:0] held;
    @(negedge clk);
    for (int i = 0; i < 5 && !ready_o; i++) @(negedge clk);
    check("ready_before_start", {31'd0, ready_o}, 32'd1);
    start_i = 1'b1;
    op_i    = op;
    amt_i   = amt;
    din_i   = din;
    @(negedge clk);
    start_i  = 1'b0;
    din_i    = 32'hFFFF_0000;
    amt_i    = 5'd7;
    op_i     = ~op;
    cycles   = 1;
    busy_cnt = 0;
    seen     = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if ((ready_o + busy_o + done_o) != 1) begin
        check("onehot_status", {29'd0, ready_o, busy_o, done_o}, 32'd0);
      end
      if (done_o) begin
        seen = 1'b1;
        break;
      end
      if (busy_o) busy_cnt++;
      if (noise && (i == 1)) begin
        start_i = 1'b1;
        din_i   = 32'hA5A5_A5A5;
        amt_i   = 5'd9;
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk);
      cycles++;
    end
    check("done_seen", {31'd0, seen}, 32'd1);
    check("latency", cycles, amt + 1);
    check("busy_cycles", busy_cnt, amt);
    check("dout", dout_o, exp_dout);
    check("cout", {31'd0, cout_o}, {31'd0, exp_cout});
    held = dout_o;
    if (noise) begin
      start_i = 1'b1;
      din_i   = 32'h5A5A_5A5A;
      amt_i   = 5'd0;
    end
    @(negedge clk);
    start_i = 1'b0;
    check("ready_after_done", {30'd0, ready_o, done_o}, 32'd2);
    check("dout_hold", dout_o, held);
    if (noise) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check("no_extra_done", {30'd0, ready_o, done_o}, 32'd2);
      end
      check("dout_after_noise", dout_o, exp_dout);
    end
  endtask

  initial begin
    vecs[0] = '{2'b00, 5'd1,  32'h9696_9696, 32'h2D2D_2D2C, 1'b1};
    vecs[1] = '{2'b01, 5'd4,  32'h3A3A_3A3A, 32'h03A3_A3A3, 1'b1};
    vecs[2] = '{2'b10, 5'd8,  32'hE6E6_E6E6, 32'hFFE6_E6E6, 1'b1};
    vecs[3] = '{2'b11, 5'd31, 32'h3232_3232, 32'h1919_1919, 1'b1};
    vecs[4] = '{2'b00, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
    vecs[5] = '{2'b11, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
    vecs[6] = '{2'b10, 5'd4,  32'h7000_000F, 32'h0700_0000, 1'b1};
    vecs[7] = '{2'b01, 5'd8,  32'hE6E6_E6E6, 32'h00E6_E6E6, 1'b1};
    vecs[8] = '{2'b11, 5'd4,  32'h1234_5678, 32'h2345_6781, 1'b1};
    vecs[9] = '{2'b00, 5'd31, 32'h0000_0003, 32'h8000_0000, 1'b1};

    rst_n   = 1'b0;
    start_i = 1'b0;
    op_i    = 2'b00;
    amt_i   = 5'd0;
    din_i   = 32'd0;
    #12;
    check("reset_dout", dout_o, 32'd0);
    check("reset_flags", {28'd0, ready_o, busy_o, done_o, cout_o}, 32'h8);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 10; v++) begin
      run_op(vecs[v].op, vecs[v].amt, vecs[v].din, vecs[v].exp_dout, vecs[v].exp_cout, 1'b0);
    end

    // Start pulses while SHIFT and DONE are in progress must not disturb the result.
    run_op(2'b00, 5'd3, 32'h0000_0001, 32'h0000_0008, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a long shift.
    @(negedge clk);
    start_i = 1'b1;
    op_i    = 2'b00;
    amt_i   = 5'd20;
    din_i   = 32'hFFFF_FFFF;
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_before_reset", {31'd0, busy_o}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_dout", dout_o, 32'd0);
    check("async_reset_flags", {28'd0, ready_o, busy_o, done_o, cout_o}, 32'h8);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done_o || !ready_o) begin
        check("no_done_after_reset", {30'd0, ready_o, done_o}, 32'd2);
      end
    end
    check("idle_after_reset", {29'd0, ready_o, busy_o, done_o}, 32'd4);
    run_op(2'b00, 5'd2, 32'h8000_0001, 32'h0000_0004, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_sequencer_32bit.md
# shift_sequencer_32bit

Multi-cycle 32-bit shift/rotate unit that sits directly upstream of the ALU logic result path. It feeds the 1-bit-per-step left-shift datapath with a sequenced operand and extends it to right logical, right arithmetic and rotate operations. It takes an operand and a 5-bit shift amount under a start/ready handshake. It applies one single-bit shift per clock and presents a registered result with a one-cycle `done` pulse.

## Interface
- No parameters; the width is fixed at 32 bits and the amount at 5 bits.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; accepted only when `ready`=1.
- `op`  in  2  operation: 00 LSL, 01 LSR, 10 ASR, 11 ROL.
- `amt`  in  5  shift amount, 0–31.
- `din`  in  32  operand.
- `ready`  out  1  high in IDLE only.
- `busy`  out  1  high in SHIFT only.
- `done`  out  1  one-cycle pulse; `dout`/`cout` are valid while it is high.
- `dout`  out  32  result register; holds its value until the next accepted start.
- `cout`  out  1  last bit shifted out (for ROL, the bit that wrapped into bit 0); 0 when `amt`=0.

## Operation
- States are IDLE, SHIFT and DONE. Encoding is free, but no other state may be reachable.
- **IDLE**: `ready`=1. On an edge with `start`=1, latch `din` into `dout`, latch `op`, and load `cnt`=`amt`. Clear `cout`.
  - If `amt`=0, go to DONE.
  - Otherwise, go to SHIFT.
- **SHIFT**: each edge applies one shift to `dout`, updates `cout`, and decrements `cnt`. When `cnt`=1 at the edge, go to DONE.
  - LSL: `dout`={`dout`[30:0],0}; `cout`=old bit 31.
  - LSR: `dout`={0,`dout`[31:1]}; `cout`=old bit 0.
  - ASR: `dout`={`dout`[31],`dout`[31:1]}; `cout`=old bit 0.
  - ROL: `dout`={`dout`[30:0],`dout`[31]}; `cout`=old bit 31.
- **DONE**: `done`=1 for exactly one cycle, then go unconditionally to IDLE. `start` is ignored in this state.
- `start` in SHIFT or DONE is ignored and has no lasting effect. `din`/`amt`/`op` changes after acceptance do not affect the operation in flight.
- `ready`, `busy` and `done` are decoded from registered state only. They are mutually exclusive and exactly one is high at any time out of reset.
- Reset (asynchronous, at any point including mid-SHIFT or DONE) forces the following immediately:
  - state IDLE, `cnt`=0
  - `dout`=0, `cout`=0
  - `done`=0, `busy`=0, `ready`=1
- After reset is released, the first rising edge with `start`=1 is accepted.

## Timing
- Start is accepted at edge k. `done` is high in the cycle following edge k+`amt`.
  - Latency is `amt`+1 cycles from acceptance to `done` deasserting, and `amt` SHIFT cycles.
  - `amt`=0: `done` is high in the cycle right after acceptance, with `dout`=`din` and `cout`=0.
  - `amt`=31: 31 SHIFT cycles.
- `ready` returns high in the cycle after `done`. The minimum start-to-start spacing is therefore `amt`+2 cycles.
- `dout`/`cout` change only on the accept edge and on SHIFT edges. Intermediate values are visible during SHIFT; consumers use them only while `done`=1 or afterwards.
- No combinational path from inputs to outputs.

## Test plan
- Reset, then LSL, `amt`=1, `din`=0x96969696 → `done` one cycle after accept; `dout`=0x2D2D2D2C, `cout`=1; `ready` high the next cycle.
- LSR, `amt`=4, `din`=0x3A3A3A3A → `busy` for 4 cycles; `dout`=0x03A3A3A3, `cout`=1.
  - Then ASR, `amt`=8, `din`=0xE6E6E6E6 → `dout`=0xFFE6E6E6, `cout`=1.
- ROL, `amt`=31, `din`=0x32323232 → `done` in the cycle after edge k+31; `dout`=0x19191919, `cout`=1.
  - Check the `ready`/`busy`/`done` one-hot property every cycle.
- `amt`=0, `din`=0xDEADBEEF, any `op` → `done` in the cycle after accept; `dout`=0xDEADBEEF, `cout`=0; no `busy` cycle.
- Pulse `start` with new `din`/`amt` during SHIFT and during DONE of an LSL, `amt`=3, `din`=0x00000001 operation → the in-flight result is unchanged: `dout`=0x00000008, `cout`=0, exactly one `done` pulse.
- Assert `rst_n`=0 mid-SHIFT, asynchronously between edges → outputs clear immediately to `dout`=0, `cout`=0, `ready`=1.
  - No `done` pulse follows.
  - After release, a new LSL, `amt`=2, `din`=0x80000001 gives `dout`=0x00000004, `cout`=0.
